ripple_adder_4bit: RTL and testbench



---
 rtl/ripple_adder_4bit_pkg.sv | 16 +
 rtl/ripple_adder_4bit_if.sv | 18 +
 rtl/ripple_adder_4bit_full_adder.sv | 15 +
 rtl/ripple_adder_4bit.sv | 48 ++++
 tb/tb_ripple_adder_4bit.sv | 134 +++++++++++++
 5 files changed

// File: rtl/ripple_adder_4bit_pkg.sv
// Shared definitions for the ripple adder slice: default width and the
// single-bit full-adder equations used by each cell of the carry chain.
package ripple_adder_4bit_pkg;

  localparam int DEF_WIDTH = 4;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry is generated by a&b, or propagated from c when exactly one operand is set.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/ripple_adder_4bit_if.sv
// Operand/result bundle of the ripple adder; the master drives operands and
// carry-in, the slave (the adder) returns sum and carry-out.
interface ripple_adder_4bit_if
  import ripple_adder_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output a, output b, output cin, input sum, input cout);
  modport slave  (input a, input b, input cin, output sum, output cout);

endinterface

// File: rtl/ripple_adder_4bit_full_adder.sv
// One-bit full adder cell; WIDTH of these are chained to form the ripple adder.
module full_adder
  import ripple_adder_4bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = fa_sum(a, b, ci);
  assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/ripple_adder_4bit.sv
// Unsigned WIDTH-bit ripple-carry adder with carry-in; result is either
// combinational or registered for one cycle depending on REG_OUT.
module ripple_adder_4bit
  import ripple_adder_4bit_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit REG_OUT = 1'b0
)(
  input logic               clk,
  input logic               rst,
  ripple_adder_4bit_if.slave bus
);

  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign c_s[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c_s[i]),
      .s  (sum_d[i]),
      .co (c_s[i+1])
    );
  end

  assign cout_d = c_s[WIDTH];

  // Output register; reset wins over capturing the current result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.sum  = REG_OUT ? sum_q  : sum_d;
  assign bus.cout = REG_OUT ? cout_q : cout_d;

endmodule

// File: tb/tb_ripple_adder_4bit.sv
// Scoreboard bench: drivers push expected {cout,sum} into queues, monitors pop
// and compare when each DUT presents a result.
module tb_ripple_adder_4bit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ripple_adder_4bit_if #(.WIDTH(4)) ifc ();
  ripple_adder_4bit_if #(.WIDTH(4)) ifr ();

  ripple_adder_4bit #(.WIDTH(4), .REG_OUT(1'b0)) u_comb (
    .clk (clk), .rst (rst), .bus (ifc)
  );
  ripple_adder_4bit #(.WIDTH(4), .REG_OUT(1'b1)) u_reg (
    .clk (clk), .rst (rst), .bus (ifr)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [4:0] q_c[$];
  string      nm_c[$];
  logic [4:0] q_r[$];
  string      nm_r[$];
  event       comb_ev;
  logic [4:0] last_r;
  bit         have_last = 1'b0;

  // Reference: exact integer sum over five bits.
  function automatic logic [4:0] ref_add(input int a, input int b, input int cin);
    int t;
    t = a + b + cin;
    return 5'(t % 32);
  endfunction

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {cout,sum}=%b, expected %b", nm, act, exp);
  endtask

  task automatic comb_apply(input string nm, input int a, input int b, input int cin);
    ifc.a   = 4'(a);
    ifc.b   = 4'(b);
    ifc.cin = 1'(cin);
    q_c.push_back(ref_add(a, b, cin));
    nm_c.push_back(nm);
    #10;
    -> comb_ev;
    #1;
  endtask

  task automatic reg_cycle(input string nm, input bit r, input int a, input int b, input int cin);
    @(negedge clk);
    rst     = r;
    ifr.a   = 4'(a);
    ifr.b   = 4'(b);
    ifr.cin = 1'(cin);
    q_r.push_back(r ? 5'd0 : ref_add(a, b, cin));
    nm_r.push_back(nm);
  endtask

  // Combinational monitor: one result per sampling event.
  initial begin
    forever begin
      @(comb_ev);
      if (q_c.size() > 0) check(nm_c.pop_front(), {ifc.cout, ifc.sum}, q_c.pop_front());
    end
  end

  // Registered monitor: result appears just after the edge following the drive.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_r.size() > 0) begin
        last_r = q_r.pop_front();
        check(nm_r.pop_front(), {ifr.cout, ifr.sum}, last_r);
        have_last = 1'b1;
      end
    end
  end

  // Between edges the registered output must hold its last value.
  initial begin
    forever begin
      @(negedge clk);
      if (have_last) check("reg_hold", {ifr.cout, ifr.sum}, last_r);
    end
  end

  initial begin
    ifr.a = 4'd0; ifr.b = 4'd0; ifr.cin = 1'b0;
    rst = 1'b1;
    comb_apply("zero_cin0", 0, 0, 0);
    comb_apply("zero_cin1", 0, 0, 1);
    rst = 1'b0;
    comb_apply("ripple_b1", 15, 1, 0);
    comb_apply("ripple_cin", 15, 0, 1);
    comb_apply("all_ones", 15, 15, 1);
    comb_apply("alt_bits", 5, 10, 0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          comb_apply("exhaustive", a, b, c);
    for (int k = 0; k < 40; k++) begin
      rst = 1'($urandom_range(0, 1));
      comb_apply("comb_rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)));
    end
    rst = 1'b0;

    reg_cycle("rst_hold1", 1'b1, 3, 4, 1);
    reg_cycle("rst_hold2", 1'b1, 3, 4, 1);
    reg_cycle("first_load", 1'b0, 7, 1, 1);
    reg_cycle("mid_rst", 1'b1, 15, 15, 0);
    reg_cycle("post_rst", 1'b0, 15, 15, 0);
    for (int k = 0; k < 60; k++)
      reg_cycle("reg_rand", ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

    for (int k = 0; k < 5 && q_r.size() > 0; k++) @(posedge clk);
    #2;
    n_total++;
    if (q_r.size() == 0 && q_c.size() == 0) n_pass++;
    else $display("FAIL drain: %0d reg / %0d comb results outstanding, expected 0",
                  q_r.size(), q_c.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
